axi_multicut: RTL and testbench
===============================

AXI_MULTICUT -- requirements
Module: axi_multicut

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADDR_WIDTH, -1, address width.
- DATA_WIDTH, -1, data width; strobe width = DATA_WIDTH/8.
- ID_WIDTH, -1, ID width.
- USER_WIDTH, -1, user width.
- NUM_CUTS, 1, spill stages per channel; 0 = combinational feed-through.
- BYPASS_MASK, 5'b00000, bits [4:0] = AW,W,B,AR,R; a set bit makes that channel feed-through regardless of NUM_CUTS.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk_i, in, 1, sole clock, rising edge.
- rst_i, in, 1, reset, asynchronous, active-high.
- in, AXI_BUS.in, -, slave side.
- out, AXI_BUS.out, -, master side.
- idle_o, out, 1, all stages empty; present only with AXI_MULTICUT_IDLE_EN.
REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 Each channel SHALL carry every payload field (AW/AR: id, addr, len, size, burst, lock, cache, prot, qos, region, user; W: data, strb, last, user; B: id, resp, user; R: id, data, resp, last, user) unmodified and in order.
REQ-005 AW, W, AR SHALL flow in->out; B, R SHALL flow out->in.
REQ-006 A non-bypassed channel with NUM_CUTS=N>0 SHALL be a chain of N two-slot stages (slot A = output slot, slot B = spill slot).
REQ-007 A stage's ready toward its upstream SHALL be ~B_full, driven from a register only (no combinational path from downstream ready).
REQ-008 A stage's valid and data toward its downstream SHALL be A_full and A_data, driven from registers only.
REQ-009 On an input handshake, data SHALL go to A if A is empty or A drains in the same cycle; otherwise to B.
REQ-010 When A drains and B is full, B SHALL move to A and B SHALL become empty in the same cycle.
REQ-011 Simultaneous input and output handshakes SHALL keep occupancy unchanged.
REQ-012 Latency through an empty channel SHALL be exactly N cycles.
REQ-013 With downstream always ready, sustained throughput SHALL be one beat per cycle.
REQ-014 Buffering capacity SHALL be 2*N beats per channel; the upstream ready SHALL deassert only when all 2*N slots are full.
REQ-015 Once a downstream valid is asserted, its payload SHALL be held stable until the handshake completes.
REQ-016 A channel with N=0 or with its BYPASS_MASK bit set SHALL connect valid, ready and payload combinationally, with zero latency.
REQ-017 Channels SHALL be fully independent; no ordering between channels is added.

Reset
REQ-018 While rst_i=1, all A_full/B_full flags and data slots SHALL clear to 0 asynchronously.
REQ-019 In reset, the following SHALL be 0: out.aw_valid, out.w_valid, out.ar_valid, in.b_valid, in.r_valid.
REQ-020 In reset, these readies SHALL be 1 for registered channels: in.aw_ready, in.w_ready, in.ar_ready, out.b_ready, out.r_ready.
REQ-021 Reset asserted mid-burst SHALL discard all buffered beats; no beat emerges after reset.

Configuration
REQ-022 When AXI_MULTICUT_IDLE_EN is defined, idle_o SHALL exist and equal 1 iff every slot of every registered channel is empty; idle_o = 1 in reset.
REQ-023 Bypassed channels SHALL count as always empty for idle_o.
REQ-024 Without AXI_MULTICUT_IDLE_EN, the idle_o port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-025 NUM_CUTS=3, AW beat addr=0x1000 at cycle 0 with out.aw_ready=1 -> out.aw_valid first high at cycle 3 with addr=0x1000.
REQ-026 NUM_CUTS=2, out.w_ready=0, 5 W beats offered -> 4 accepted, in.w_ready=0 from the cycle after the 4th; out.w_ready raised -> beats emerge in order, with data unchanged.
REQ-027 NUM_CUTS=1, 100 back-to-back R beats, in.r_ready=1 -> 100 beats in 101 cycles with no gaps.
REQ-028 BYPASS_MASK=5'b00100 (B bypassed), NUM_CUTS=2 -> in.b_valid follows out.b_valid in the same cycle; AW latency stays 2.
REQ-029 3 AR beats buffered, rst_i pulsed for 1 cycle -> out.ar_valid=0 immediately and in.ar_ready=1; no stale beat after release.
REQ-030 AXI_MULTICUT_IDLE_EN defined, single W beat -> idle_o falls the cycle after the input handshake and rises the cycle after the output handshake.

Source files
------------

// File: rtl/axi_multicut_if.sv
// AXI_BUS: full AXI4 channel set (AW, W, B, AR, R) with valid/ready handshakes.
// Modport "in" is the view of a block receiving requests; "out" is the view of a block issuing them.
interface AXI_BUS #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_lock;
    logic [3:0]            aw_cache;
    logic [2:0]            aw_prot;
    logic [3:0]            aw_qos;
    logic [3:0]            aw_region;
    logic [USER_WIDTH-1:0] aw_user;
    logic                  aw_valid;
    logic                  aw_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_last;
    logic [USER_WIDTH-1:0] w_user;
    logic                  w_valid;
    logic                  w_ready;

    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_valid;
    logic                  b_ready;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_lock;
    logic [3:0]            ar_cache;
    logic [2:0]            ar_prot;
    logic [3:0]            ar_qos;
    logic [3:0]            ar_region;
    logic [USER_WIDTH-1:0] ar_user;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    modport in (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport out (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_multicut.sv
// AXI pipeline cut: NUM_CUTS fully registered two-slot stages per channel, per-channel bypass.
// Optional idle_o status output is built only when AXI_MULTICUT_IDLE_EN is defined.

// Two-slot spill stage. A beat transfers on a side in any cycle where valid and ready are both
// high at the rising edge; valid never waits on ready, and once raised, valid and data hold until transfer.
module axi_multicut_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
`ifdef AXI_MULTICUT_IDLE_EN
    ,
    output logic         empty
`endif
);
    logic         a_full;
    logic         b_full;
    logic [W-1:0] a_data;
    logic [W-1:0] b_data;
    logic         in_hs;

    assign in_ready  = ~b_full;
    assign out_valid = a_full;
    assign out_data  = a_data;
    assign in_hs     = in_valid & ~b_full;

`ifdef AXI_MULTICUT_IDLE_EN
    // B is only ever occupied while A is, so A alone tells whether the stage is empty.
    assign empty = ~a_full;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_full <= 1'b0;
            b_full <= 1'b0;
            a_data <= '0;
            b_data <= '0;
        end else if (a_full && !out_ready) begin
            if (in_hs) begin
                b_full <= 1'b1;
                b_data <= in_data;
            end
        end else if (b_full) begin
            // A drains while B waits: B refills A; upstream was stalled so nothing new arrives.
            a_data <= b_data;
            b_full <= 1'b0;
        end else begin
            a_full <= in_hs;
            if (in_hs) begin
                a_data <= in_data;
            end
        end
    end
endmodule

// One channel: either a wire-through or a chain of N spill stages.
module axi_multicut_chan #(
    parameter int W      = 1,
    parameter int N      = 1,
    parameter bit BYPASS = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
`ifdef AXI_MULTICUT_IDLE_EN
    ,
    output logic         empty
`endif
);
    if (BYPASS || N == 0) begin : g_thru
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign dn_valid = up_valid;
        assign up_ready = dn_ready;
        assign dn_data  = up_data;
`ifdef AXI_MULTICUT_IDLE_EN
        assign empty = 1'b1;
`endif
    end else begin : g_cut
        logic [N:0]   v;
        logic [N:0]   r;
        logic [W-1:0] d [N+1];
`ifdef AXI_MULTICUT_IDLE_EN
        logic [N-1:0] stage_empty;
        assign empty = &stage_empty;
`endif

        assign v[0]     = up_valid;
        assign up_ready = r[0];
        assign d[0]     = up_data;
        assign dn_valid = v[N];
        assign r[N]     = dn_ready;
        assign dn_data  = d[N];

        for (genvar i = 0; i < N; i++) begin : g_stage
            axi_multicut_stage #(.W(W)) u_stage (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (v[i]),
                .in_ready  (r[i]),
                .in_data   (d[i]),
                .out_valid (v[i+1]),
                .out_ready (r[i+1]),
                .out_data  (d[i+1])
`ifdef AXI_MULTICUT_IDLE_EN
                ,
                .empty     (stage_empty[i])
`endif
            );
        end
    end
endmodule

module axi_multicut #(
    parameter int         ADDR_WIDTH  = -1,
    parameter int         DATA_WIDTH  = -1,
    parameter int         ID_WIDTH    = -1,
    parameter int         USER_WIDTH  = -1,
    parameter int         NUM_CUTS    = 1,
    parameter logic [4:0] BYPASS_MASK = 5'b00000
) (
    input  logic clk_i,
    input  logic rst_i,
    AXI_BUS.in   in,
    AXI_BUS.out  out
`ifdef AXI_MULTICUT_IDLE_EN
    ,
    output logic idle_o
`endif
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // id + addr + user plus len(8) size(3) burst(2) lock(1) cache(4) prot(3) qos(4) region(4)
    localparam int AX_W = ID_WIDTH + ADDR_WIDTH + USER_WIDTH + 29;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1 + USER_WIDTH;
    localparam int B_W  = ID_WIDTH + 2 + USER_WIDTH;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH;

    logic [AX_W-1:0] aw_up, aw_dn, ar_up, ar_dn;
    logic [W_W-1:0]  w_up, w_dn;
    logic [B_W-1:0]  b_up, b_dn;
    logic [R_W-1:0]  r_up, r_dn;

    assign aw_up = {in.aw_id, in.aw_addr, in.aw_len, in.aw_size, in.aw_burst, in.aw_lock,
                    in.aw_cache, in.aw_prot, in.aw_qos, in.aw_region, in.aw_user};
    assign {out.aw_id, out.aw_addr, out.aw_len, out.aw_size, out.aw_burst, out.aw_lock,
            out.aw_cache, out.aw_prot, out.aw_qos, out.aw_region, out.aw_user} = aw_dn;
    assign w_up = {in.w_data, in.w_strb, in.w_last, in.w_user};
    assign {out.w_data, out.w_strb, out.w_last, out.w_user} = w_dn;
    assign ar_up = {in.ar_id, in.ar_addr, in.ar_len, in.ar_size, in.ar_burst, in.ar_lock,
                    in.ar_cache, in.ar_prot, in.ar_qos, in.ar_region, in.ar_user};
    assign {out.ar_id, out.ar_addr, out.ar_len, out.ar_size, out.ar_burst, out.ar_lock,
            out.ar_cache, out.ar_prot, out.ar_qos, out.ar_region, out.ar_user} = ar_dn;
    // Response channels run backwards: the master side is upstream.
    assign b_up = {out.b_id, out.b_resp, out.b_user};
    assign {in.b_id, in.b_resp, in.b_user} = b_dn;
    assign r_up = {out.r_id, out.r_data, out.r_resp, out.r_last, out.r_user};
    assign {in.r_id, in.r_data, in.r_resp, in.r_last, in.r_user} = r_dn;

`ifdef AXI_MULTICUT_IDLE_EN
    logic aw_empty, w_empty, b_empty, ar_empty, r_empty;
    assign idle_o = aw_empty & w_empty & b_empty & ar_empty & r_empty;
`endif

    axi_multicut_chan #(.W(AX_W), .N(NUM_CUTS), .BYPASS(BYPASS_MASK[4])) u_aw (
        .clk(clk_i), .rst(rst_i),
        .up_valid(in.aw_valid), .up_ready(in.aw_ready), .up_data(aw_up),
        .dn_valid(out.aw_valid), .dn_ready(out.aw_ready), .dn_data(aw_dn)
`ifdef AXI_MULTICUT_IDLE_EN
        , .empty(aw_empty)
`endif
    );

    axi_multicut_chan #(.W(W_W), .N(NUM_CUTS), .BYPASS(BYPASS_MASK[3])) u_w (
        .clk(clk_i), .rst(rst_i),
        .up_valid(in.w_valid), .up_ready(in.w_ready), .up_data(w_up),
        .dn_valid(out.w_valid), .dn_ready(out.w_ready), .dn_data(w_dn)
`ifdef AXI_MULTICUT_IDLE_EN
        , .empty(w_empty)
`endif
    );

    axi_multicut_chan #(.W(B_W), .N(NUM_CUTS), .BYPASS(BYPASS_MASK[2])) u_b (
        .clk(clk_i), .rst(rst_i),
        .up_valid(out.b_valid), .up_ready(out.b_ready), .up_data(b_up),
        .dn_valid(in.b_valid), .dn_ready(in.b_ready), .dn_data(b_dn)
`ifdef AXI_MULTICUT_IDLE_EN
        , .empty(b_empty)
`endif
    );

    axi_multicut_chan #(.W(AX_W), .N(NUM_CUTS), .BYPASS(BYPASS_MASK[1])) u_ar (
        .clk(clk_i), .rst(rst_i),
        .up_valid(in.ar_valid), .up_ready(in.ar_ready), .up_data(ar_up),
        .dn_valid(out.ar_valid), .dn_ready(out.ar_ready), .dn_data(ar_dn)
`ifdef AXI_MULTICUT_IDLE_EN
        , .empty(ar_empty)
`endif
    );

    axi_multicut_chan #(.W(R_W), .N(NUM_CUTS), .BYPASS(BYPASS_MASK[0])) u_r (
        .clk(clk_i), .rst(rst_i),
        .up_valid(out.r_valid), .up_ready(out.r_ready), .up_data(r_up),
        .dn_valid(in.r_valid), .dn_ready(in.r_ready), .dn_data(r_dn)
`ifdef AXI_MULTICUT_IDLE_EN
        , .empty(r_empty)
`endif
    );
endmodule

// File: tb/tb_axi_multicut.sv
// Bench for axi_multicut: dut A (NUM_CUTS=2, B bypassed) and dut B (NUM_CUTS=3).
// Directed stimulus pushes expected beats into queues; a negedge monitor pops and compares.
`define AW_PAY(b) {b.aw_id, b.aw_addr, b.aw_len, b.aw_size, b.aw_burst, b.aw_lock, b.aw_cache, b.aw_prot, b.aw_qos, b.aw_region, b.aw_user}
`define AR_PAY(b) {b.ar_id, b.ar_addr, b.ar_len, b.ar_size, b.ar_burst, b.ar_lock, b.ar_cache, b.ar_prot, b.ar_qos, b.ar_region, b.ar_user}
`define W_PAY(b) {b.w_data, b.w_strb, b.w_last, b.w_user}
`define R_PAY(b) {b.r_id, b.r_data, b.r_resp, b.r_last, b.r_user}
`define B_PAY(b) {b.b_id, b.b_resp, b.b_user}

module tb_axi_multicut;
    localparam int AXW = 67;
    localparam int WW  = 39;
    localparam int RW  = 41;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [127:0] aw_a_q[$];
    logic [127:0] aw_b_q[$];
    logic [127:0] w_q[$];
    logic [127:0] ar_q[$];
    logic [127:0] r_q[$];

    int r_cnt = 0;
    int r_first = 0;
    int r_last = 0;
    logic         w_prev_stall = 1'b0;
    logic [127:0] w_prev_data = '0;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2)) a_in ();
    AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2)) a_out ();
    AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2)) b_in ();
    AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2)) b_out ();

`ifdef AXI_MULTICUT_IDLE_EN
    logic idle_a;
    logic idle_b;
`endif

    axi_multicut #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2),
                   .NUM_CUTS(2), .BYPASS_MASK(5'b00100)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .in    (a_in),
        .out   (a_out)
`ifdef AXI_MULTICUT_IDLE_EN
        , .idle_o(idle_a)
`endif
    );

    axi_multicut #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2),
                   .NUM_CUTS(3), .BYPASS_MASK(5'b00000)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .in    (b_in),
        .out   (b_out)
`ifdef AXI_MULTICUT_IDLE_EN
        , .idle_o(idle_b)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got a beat expected none (cycle %0d)", name, cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic clear_all;
        `AW_PAY(a_in) = 67'd0; a_in.aw_valid = 1'b0;
        `W_PAY(a_in)  = 39'd0; a_in.w_valid  = 1'b0;
        `AR_PAY(a_in) = 67'd0; a_in.ar_valid = 1'b0;
        a_in.b_ready = 1'b0;   a_in.r_ready  = 1'b0;
        `AW_PAY(b_in) = 67'd0; b_in.aw_valid = 1'b0;
        `W_PAY(b_in)  = 39'd0; b_in.w_valid  = 1'b0;
        `AR_PAY(b_in) = 67'd0; b_in.ar_valid = 1'b0;
        b_in.b_ready = 1'b0;   b_in.r_ready  = 1'b0;
        a_out.aw_ready = 1'b0; a_out.w_ready = 1'b0; a_out.ar_ready = 1'b0;
        `B_PAY(a_out) = 8'd0;  a_out.b_valid = 1'b0;
        `R_PAY(a_out) = 41'd0; a_out.r_valid = 1'b0;
        b_out.aw_ready = 1'b0; b_out.w_ready = 1'b0; b_out.ar_ready = 1'b0;
        `B_PAY(b_out) = 8'd0;  b_out.b_valid = 1'b0;
        `R_PAY(b_out) = 41'd0; b_out.r_valid = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out.aw_valid && a_out.aw_ready) begin
                if (aw_a_q.size() == 0) unexpected("aw_a_beat");
                else chk("aw_a_payload", 128'(`AW_PAY(a_out)), aw_a_q.pop_front());
            end
            if (b_out.aw_valid && b_out.aw_ready) begin
                if (aw_b_q.size() == 0) unexpected("aw_b_beat");
                else chk("aw_b_payload", 128'(`AW_PAY(b_out)), aw_b_q.pop_front());
            end
            if (a_out.w_valid && a_out.w_ready) begin
                if (w_q.size() == 0) unexpected("w_beat");
                else chk("w_payload", 128'(`W_PAY(a_out)), w_q.pop_front());
            end
            if (a_out.ar_valid && a_out.ar_ready) begin
                if (ar_q.size() == 0) unexpected("ar_beat");
                else chk("ar_payload", 128'(`AR_PAY(a_out)), ar_q.pop_front());
            end
            if (b_in.r_valid && b_in.r_ready) begin
                if (r_q.size() == 0) unexpected("r_beat");
                else chk("r_payload", 128'(`R_PAY(b_in)), r_q.pop_front());
                if (r_cnt == 0) r_first = cyc;
                r_last = cyc;
                r_cnt++;
            end
            if (w_prev_stall) begin
                chk("w_hold_valid", a_out.w_valid, 1'b1);
                chk("w_hold_data", 128'(`W_PAY(a_out)), w_prev_data);
            end
        end
        w_prev_stall = !rst && a_out.w_valid && !a_out.w_ready;
        w_prev_data  = 128'(`W_PAY(a_out));
    end

    initial begin
        int acc;
        int r_start;
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset values
        chk("rst_a_aw_valid", a_out.aw_valid, 1'b0);
        chk("rst_a_w_valid", a_out.w_valid, 1'b0);
        chk("rst_a_ar_valid", a_out.ar_valid, 1'b0);
        chk("rst_a_r_valid", a_in.r_valid, 1'b0);
        chk("rst_a_aw_ready", a_in.aw_ready, 1'b1);
        chk("rst_a_w_ready", a_in.w_ready, 1'b1);
        chk("rst_a_ar_ready", a_in.ar_ready, 1'b1);
        chk("rst_a_r_ready", a_out.r_ready, 1'b1);
        chk("rst_b_b_ready", b_out.b_ready, 1'b1);
        chk("rst_b_b_valid", b_in.b_valid, 1'b0);
`ifdef AXI_MULTICUT_IDLE_EN
        chk("rst_idle", idle_a, 1'b1);
`endif
        tick();
        rst = 1'b0;

        // three-cut AW latency and full payload
        b_out.aw_ready = 1'b1;
        `AW_PAY(b_in) = {4'h5, 32'h0000_1000, 8'd3, 3'd2, 2'd1, 1'b1, 4'ha, 3'd5, 4'h6, 4'h9, 2'h2};
        b_in.aw_valid = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk("aw3_latency", b_out.aw_valid, 1'((k == 3)));
            if (k == 0) begin
                chk("aw3_in_ready", b_in.aw_ready, 1'b1);
                aw_b_q.push_back(128'(`AW_PAY(b_in)));
            end
            tick();
            b_in.aw_valid = 1'b0;
        end

        // two-cut AW latency on the dut with B bypassed
        a_out.aw_ready = 1'b1;
        `AW_PAY(a_in) = {4'hc, 32'h0000_2000, 8'd15, 3'd3, 2'd2, 1'b0, 4'h3, 3'd1, 4'hf, 4'h1, 2'h1};
        a_in.aw_valid = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk("aw2_latency", a_out.aw_valid, 1'((k == 2)));
            if (k == 0) aw_a_q.push_back(128'(`AW_PAY(a_in)));
            tick();
            a_in.aw_valid = 1'b0;
        end

        // bypassed B channel: same-cycle valid, payload and ready
        `B_PAY(a_out) = {4'h3, 2'b10, 2'h1};
        a_out.b_valid = 1'b1;
        a_in.b_ready = 1'b0;
        #1;
        chk("b_thru_valid", a_in.b_valid, 1'b1);
        chk("b_thru_payload", `B_PAY(a_in), 8'h39);
        chk("b_thru_ready_lo", a_out.b_ready, 1'b0);
        a_in.b_ready = 1'b1;
        #1;
        chk("b_thru_ready_hi", a_out.b_ready, 1'b1);
        tick();
        a_out.b_valid = 1'b0;
        a_in.b_ready = 1'b0;
        #1;
        chk("b_thru_valid_lo", a_in.b_valid, 1'b0);

        // W fill with downstream stalled: 4 slots, 5th beat refused
        a_out.w_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            `W_PAY(a_in) = {32'hc0de_0000 + 32'(acc), 4'hf - 4'(acc), 1'((acc == 4)), 2'(acc)};
            a_in.w_valid = 1'b1;
            @(negedge clk);
            chk("w_fill_ready", a_in.w_ready, 1'((c < 4)));
            if (a_in.w_ready) begin
                w_q.push_back(128'(`W_PAY(a_in)));
                acc++;
            end
            tick();
        end
        a_in.w_valid = 1'b0;
        chk("w_accepted", 32'(acc), 32'd4);
        a_out.w_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("w_ready_after_drain", a_in.w_ready, 1'b1);
        tick();

`ifdef AXI_MULTICUT_IDLE_EN
        // idle falls after the input handshake and rises after the output handshake
        `W_PAY(a_in) = {32'h1d1e_0001, 4'h5, 1'b1, 2'h3};
        a_in.w_valid = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk("idle_seq", idle_a, 1'((k == 0 || k == 3)));
            if (k == 0) w_q.push_back(128'(`W_PAY(a_in)));
            tick();
            a_in.w_valid = 1'b0;
        end
`endif

        // 100 back-to-back R beats through three cuts
        b_in.r_ready = 1'b1;
        r_start = cyc;
        for (int i = 0; i < 100; i++) begin
            `R_PAY(b_out) = {4'(i), (32'(i) * 32'h0101_0101) ^ 32'h5a5a_0000, 2'(i), 1'((i == 99)), 2'(i + 1)};
            b_out.r_valid = 1'b1;
            @(negedge clk);
            chk("r_up_ready", b_out.r_ready, 1'b1);
            r_q.push_back(128'(`R_PAY(b_out)));
            tick();
        end
        b_out.r_valid = 1'b0;
        for (int t = 0; t < 20 && r_cnt < 100; t++) tick();
        chk("r_count", 32'(r_cnt), 32'd100);
        chk("r_first_latency", 32'(r_first - r_start), 32'd3);
        chk("r_no_gaps", 32'(r_last - r_first), 32'd99);

        // AR beats buffered, then reset discards them
        a_out.ar_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            `AR_PAY(a_in) = {4'(i), 32'h0000_3000 + 32'(i * 4), 8'(i), 3'd2, 2'd1, 1'b0, 4'h2, 3'd0, 4'h0, 4'h0, 2'h0};
            a_in.ar_valid = 1'b1;
            @(negedge clk);
            chk("ar_fill_ready", a_in.ar_ready, 1'b1);
            tick();
        end
        a_in.ar_valid = 1'b0;
        @(negedge clk);
        chk("ar_buffered_valid", a_out.ar_valid, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("ar_rst_valid", a_out.ar_valid, 1'b0);
        chk("ar_rst_ready", a_in.ar_ready, 1'b1);
        tick();
        rst = 1'b0;
        a_out.ar_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ar_no_stale", a_out.ar_valid, 1'b0);
            tick();
        end
        `AR_PAY(a_in) = {4'h7, 32'h0000_4440, 8'd1, 3'd1, 2'd0, 1'b1, 4'h5, 3'd6, 4'h2, 4'h3, 2'h3};
        a_in.ar_valid = 1'b1;
        @(negedge clk);
        ar_q.push_back(128'(`AR_PAY(a_in)));
        tick();
        a_in.ar_valid = 1'b0;
        repeat (5) tick();

        // final report
        chk("aw_a_drained", 32'(aw_a_q.size()), 32'd0);
        chk("aw_b_drained", 32'(aw_b_q.size()), 32'd0);
        chk("w_drained", 32'(w_q.size()), 32'd0);
        chk("ar_drained", 32'(ar_q.size()), 32'd0);
        chk("r_drained", 32'(r_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
